// File: rtl/float_accum_stream.sv
// rtl/float_accum_stream.sv - streaming frame accumulator for the unsigned mini-float format
// Sums one float per accepted beat; reports total, beat count and sticky saturation per frame.
module float_accum_stream #(
  parameter int EXP_W = 3,
  parameter int MAN_W = 5,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] out_data,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_sat
);

  localparam int W = EXP_W + MAN_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, state_next;
  logic [W-1:0]     acc;
  logic [CNT_W-1:0] count;
  logic             sat;
  logic             accept;
  logic             out_fire;

  logic [EXP_W-1:0] a_exp, b_exp, big_exp, small_exp, diff;
  logic [MAN_W-1:0] a_man, b_man, big_man, small_man, shifted;
  logic [MAN_W:0]   sum;
  logic [W-1:0]     add_res;
  logic             add_sat;

  // acc is zero in IDLE, so add(acc, in_data) also covers the first beat of a frame.
  always_comb begin
    a_exp     = acc[W-1:MAN_W];
    a_man     = acc[MAN_W-1:0];
    b_exp     = in_data[W-1:MAN_W];
    b_man     = in_data[MAN_W-1:0];
    big_exp   = a_exp;
    big_man   = a_man;
    small_exp = b_exp;
    small_man = b_man;
    if (b_exp > a_exp) begin
      big_exp   = b_exp;
      big_man   = b_man;
      small_exp = a_exp;
      small_man = a_man;
    end
    diff    = big_exp - small_exp;
    shifted = (32'(diff) >= MAN_W) ? '0 : (small_man >> diff);
    sum     = {1'b0, big_man} + {1'b0, shifted};
    add_sat = 1'b0;
    if (!sum[MAN_W]) begin
      add_res = {big_exp, sum[MAN_W-1:0]};
    end else if (!(&big_exp)) begin
      add_res = {big_exp + 1'b1, sum[MAN_W:1]};
    end else begin
      add_res = {W{1'b1}};
      add_sat = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) state_next = in_last ? DONE : ACCUM;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        acc <= add_res;
        if (state == IDLE) begin
          count <= CNT_ONE;
          sat   <= add_sat;
        end else begin
          count <= (count == CNT_MAX) ? count : count + CNT_ONE;
          sat   <= sat | add_sat;
        end
      end else if (out_fire) begin
        acc   <= '0;
        count <= '0;
        sat   <= 1'b0;
      end
    end
  end

  // Accumulator registers are frozen in DONE, so they serve directly as the result.
  assign out_data  = acc;
  assign out_count = count;
  assign out_sat   = sat;

endmodule

// File: tb/tb_float_accum_stream.sv
// tb/tb_float_accum_stream.sv - directed self-checking bench for float_accum_stream
module tb_float_accum_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_count;
  logic       out_sat;

  int n_checks = 0;
  int n_pass   = 0;

  float_accum_stream #(.EXP_W(3), .MAN_W(5), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready", in_ready, 1);
    @(posedge clk);
  endtask

  task automatic expect_result(input string tag, input logic [7:0] d, input logic [7:0] c,
                               input logic s);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_count"}, out_count, c);
    check({tag, "_sat"}, out_sat, s);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_done"}, out_valid, 0);
    check({tag, "_ready"}, in_ready, 1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_sat", out_sat, 0);

    beat(8'h21, 0); beat(8'h21, 1);
    expect_result("aligned", 8'h22, 2, 0);

    beat(8'h3F, 0); beat(8'h3F, 1);
    expect_result("carry", 8'h5F, 2, 0);

    beat(8'h90, 0); beat(8'h1F, 1);
    expect_result("align4", 8'h91, 2, 0);

    beat(8'hD0, 0); beat(8'h1F, 1);
    expect_result("align6", 8'hD0, 2, 0);

    beat(8'hFF, 0); beat(8'hE1, 0); beat(8'h00, 1);
    expect_result("sat", 8'hFF, 3, 1);
    beat(8'h5A, 1);
    expect_result("sat_clr", 8'h5A, 1, 0);

    // backpressure: in_valid stays high with a would-be beat while the result waits
    beat(8'h5A, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h3F; in_last = 1'b1;
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 8'h5A);
      check("bp_count", out_count, 1);
      check("bp_in_ready", in_ready, 0);
      if (i == 3) out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    check("bp_after_ready", in_ready, 1);
    check("bp_after_valid", out_valid, 0);

    beat(8'h3F, 0); beat(8'h3F, 0);
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", out_count, 0);
    beat(8'h21, 1);
    expect_result("post_rst", 8'h21, 1, 0);

    // consumer already ready when the result appears
    out_ready = 1'b1;
    beat(8'h90, 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check("pre_ready_valid", out_valid, 1);
    check("pre_ready_data", out_data, 8'h90);
    @(negedge clk);
    check("pre_ready_done", out_valid, 0);
    out_ready = 1'b0;

    for (int i = 0; i < 259; i++) beat(8'h00, 0);
    beat(8'h01, 1);
    expect_result("cnt_sat", 8'h01, 8'hFF, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
